// File: rtl/regfile_arbiter_pkg.sv
// Shared types and constants for the register-file arbiter.
package regfile_arb_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 8;
   localparam int IDX_W_MAX  = 2;

   localparam logic ERR_NONE    = 1'b0;
   localparam logic ERR_ILLEGAL = 1'b1;
   localparam logic ERR_LOCKED  = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      CAPTURE,
      RESP
   } state_t;

   typedef struct packed {
      logic                  we;
      logic [ADDR_W_DEF-1:0] addr;
      logic [DATA_W_DEF-1:0] wdata;
      logic [IDX_W_MAX-1:0]  idx;
   } txn_t;

endpackage

// File: rtl/regfile_arbiter_if.sv
// Requester, response and register-file port bundle for regfile_arbiter.
interface regfile_arbiter_if #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8
);
   logic [NUM_REQ-1:0]             req_valid;
   logic [NUM_REQ-1:0]             req_we;
   logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
   logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
   logic [NUM_REQ-1:0]             req_ready;
   logic [NUM_REQ-1:0]             rsp_valid;
   logic [NUM_REQ-1:0]             rsp_ready;
   logic [DATA_W-1:0]              rsp_rdata;
   logic                           rsp_err;
   logic                           rf_write;
   logic                           rf_read;
   logic [ADDR_W-1:0]              rf_write_addr;
   logic [DATA_W-1:0]              rf_write_data;
   logic [ADDR_W-1:0]              rf_read_addr;
   logic [DATA_W-1:0]              rf_read_data;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready, rf_read_data,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  rf_write, rf_read, rf_write_addr, rf_write_data, rf_read_addr
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready, rf_read_data,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output rf_write, rf_read, rf_write_addr, rf_write_data, rf_read_addr
   );
endinterface

// File: rtl/regfile_arbiter_rr_arbiter.sv
// Round-robin grant: first valid index at or after the pointer, wrapping.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NUM_REQ-1:0] valid,
   input  logic               advance,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   idx
);
   logic [IDX_W-1:0]   ptr_reg;
   logic [NUM_REQ-1:0] hi_mask;
   logic [NUM_REQ-1:0] hi_req;
   logic [NUM_REQ-1:0] sel;

   // Requests at or above the pointer take priority; otherwise wrap to the lowest.
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
         assign hi_mask[gi] = (ptr_reg <= IDX_W'(gi));
      end
   endgenerate

   assign hi_req = valid & hi_mask;
   assign sel    = (|hi_req) ? hi_req : valid;

   always_comb begin
      grant = '0;
      idx   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (sel[i]) begin
            grant    = '0;
            grant[i] = 1'b1;
            idx      = IDX_W'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr_reg <= '0;
      end else if (advance) begin
         ptr_reg <= (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
      end
   end
endmodule

// File: rtl/regfile_arbiter.sv
// Shares the register file port between NUM_REQ requesters, one transaction at a time.
// Define REGFILE_ARB_WRITE_LOCK_EN to add cfg_lock, which blocks writes from requesters other than 0.
module regfile_arbiter
   import regfile_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int NUMREGS = 67,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF
) (
   input  logic clk,
   input  logic reset_n,
`ifdef REGFILE_ARB_WRITE_LOCK_EN
   input  logic cfg_lock,
`endif
   regfile_arbiter_if.slave bus
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_t             state_reg;
   txn_t               txn_reg;
   logic               err_reg;
   logic               wr_go_reg;
   logic               rd_go_reg;
   logic [NUM_REQ-1:0] rsp_valid_reg;
   logic [DATA_W-1:0]  rsp_rdata_reg;
   logic               rsp_err_reg;
   logic [ADDR_W-1:0]  rf_write_addr_reg;
   logic [DATA_W-1:0]  rf_write_data_reg;
   logic [ADDR_W-1:0]  rf_read_addr_reg;

   logic [NUM_REQ-1:0] grant;
   logic [IDX_W-1:0]   win_idx;
   logic               arb_go;
   logic               win_we;
   logic               win_legal;
   logic [ADDR_W-1:0]  win_addr;
   logic [DATA_W-1:0]  win_wdata;
   logic [NUM_REQ-1:0] txn_sel;
   logic               lock_hit;

   assign arb_go = (state_reg == IDLE) && (|bus.req_valid);

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .clk     (clk),
      .reset_n (reset_n),
      .valid   (bus.req_valid),
      .advance (arb_go),
      .grant   (grant),
      .idx     (win_idx)
   );

   assign win_we    = bus.req_we[win_idx];
   assign win_addr  = bus.req_addr[win_idx];
   assign win_wdata = bus.req_wdata[win_idx];
   assign win_legal = (32'(win_addr) < 32'(NUMREGS));
   assign txn_sel   = NUM_REQ'(1) << txn_reg.idx;

`ifdef REGFILE_ARB_WRITE_LOCK_EN
   // Lock is evaluated while the write strobe would be issued.
   assign lock_hit = cfg_lock && txn_reg.we && (txn_reg.idx != '0);
`else
   assign lock_hit = 1'b0;
`endif

   // Accept is combinational so the winner sees req_ready in its own valid cycle.
   assign bus.req_ready     = (arb_go && reset_n) ? grant : '0;
   assign bus.rf_write      = wr_go_reg & ~lock_hit;
   assign bus.rf_read       = rd_go_reg;
   assign bus.rf_write_addr = rf_write_addr_reg;
   assign bus.rf_write_data = rf_write_data_reg;
   assign bus.rf_read_addr  = rf_read_addr_reg;
   assign bus.rsp_valid     = rsp_valid_reg;
   assign bus.rsp_rdata     = rsp_rdata_reg;
   assign bus.rsp_err       = rsp_err_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg         <= IDLE;
         txn_reg           <= '0;
         err_reg           <= ERR_NONE;
         wr_go_reg         <= 1'b0;
         rd_go_reg         <= 1'b0;
         rsp_valid_reg     <= '0;
         rsp_rdata_reg     <= '0;
         rsp_err_reg       <= ERR_NONE;
         rf_write_addr_reg <= '0;
         rf_write_data_reg <= '0;
         rf_read_addr_reg  <= '0;
      end else begin
         wr_go_reg <= 1'b0;
         rd_go_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (arb_go) begin
                  txn_reg   <= '{we: win_we, addr: win_addr, wdata: win_wdata,
                                 idx: IDX_W_MAX'(win_idx)};
                  err_reg   <= win_legal ? ERR_NONE : ERR_ILLEGAL;
                  wr_go_reg <= win_legal && win_we;
                  rd_go_reg <= win_legal && !win_we;
                  if (win_legal && win_we) begin
                     rf_write_addr_reg <= win_addr;
                     rf_write_data_reg <= win_wdata;
                  end
                  if (win_legal && !win_we) begin
                     rf_read_addr_reg <= win_addr;
                  end
                  state_reg <= ISSUE;
               end
            end
            ISSUE: begin
               if (txn_reg.we) begin
                  rsp_valid_reg <= txn_sel;
                  rsp_rdata_reg <= '0;
                  rsp_err_reg   <= err_reg | (lock_hit ? ERR_LOCKED : ERR_NONE);
                  state_reg     <= RESP;
               end else begin
                  state_reg <= CAPTURE;
               end
            end
            CAPTURE: begin
               rsp_valid_reg <= txn_sel;
               rsp_rdata_reg <= err_reg ? '0 : bus.rf_read_data;
               rsp_err_reg   <= err_reg;
               state_reg     <= RESP;
            end
            RESP: begin
               if (|(bus.rsp_ready & rsp_valid_reg)) begin
                  rsp_valid_reg <= '0;
                  state_reg     <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
Shares the configuration register file's single write/read port between NUM_REQ independent requesters, e.g. the external SPI/UART config slave and an on-chip calibration sequencer.
- Arbitrates round-robin and executes one transaction at a time.
- Sequences the register file's write/read strobes.
- Returns a per-requester response with read data and an error flag.
- Sits between the requester interfaces and the register file inside the digital core.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
NUMREGS, 67, implemented register count; addresses >= NUMREGS are illegal
ADDR_W, 8, register address width
DATA_W, 8, register data width

Ports:
clk  input  1  system clock
reset_n  input  1  async active-low reset
req_valid  input  NUM_REQ  per-requester request valid
req_we  input  NUM_REQ  1=write, 0=read
req_addr  input  NUM_REQ x ADDR_W  request address
req_wdata  input  NUM_REQ x DATA_W  write data
req_ready  output  NUM_REQ  accept strobe, one-hot, one cycle
rsp_valid  output  NUM_REQ  response valid, held until rsp_ready
rsp_ready  input  NUM_REQ  response consume
rsp_rdata  output  DATA_W  read data for the responding requester
rsp_err  output  1  illegal-address (or locked) flag for the responding requester
rf_write  output  1  register file write strobe
rf_read  output  1  register file read strobe
rf_write_addr  output  ADDR_W  register file write address
rf_write_data  output  DATA_W  register file write data
rf_read_addr  output  ADDR_W  register file read address
rf_read_data  input  DATA_W  register file read data (registered, valid one cycle after rf_read)

Behaviour:
- Reset:
  - state=IDLE, rr pointer=0.
  - All outputs 0: req_ready, rsp_valid, rsp_rdata, rsp_err, rf_write, rf_read, rf_* buses.
  - Reset mid-transaction aborts it: no strobe, no response.
- Requester rule: holds req_valid/req_we/req_addr/req_wdata stable until req_ready.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - If any req_valid, the winner is chosen combinationally: first valid index at or after the rr pointer, wrapping.
  - req_ready[winner]=1 in that same cycle; we/addr/wdata/requester index are latched.
  - rr pointer <= (winner+1) mod NUM_REQ.
  - Next state ISSUE.
  - No valid: stay in IDLE, req_ready=0.
- ISSUE (one cycle):
  - Legal address (addr < NUMREGS): rf_write=1 with rf_write_addr/rf_write_data for a write; rf_read=1 with rf_read_addr for a read.
  - Illegal address: no strobe, err latched 1.
  - Write -> RESP. Read -> CAPTURE.
- CAPTURE (reads only): latch rf_read_data, or 0x00 if the address is illegal. Next state RESP.
- RESP:
  - rsp_valid[idx]=1, rsp_rdata (0x00 for writes), rsp_err.
  - Leave when rsp_ready[idx]=1, returning to IDLE. New arbitration starts the cycle after.
  - rsp_rdata/rsp_err hold their last value after the response.
- Latency from the accept cycle (cycle 0): write rsp_valid at cycle 2, read rsp_valid at cycle 3.
- Throughput: at most one transaction per 3 cycles (write) or 4 cycles (read), with rsp_ready held high.
- Requests arriving outside IDLE wait; req_ready stays 0.
- Simultaneous valids: the rr pointer decides; starvation-free.
- rf_write and rf_read are never both high. Each strobe lasts exactly one cycle.

Optional Feature:
REGFILE_ARB_WRITE_LOCK_EN
- Defined:
  - Adds input cfg_lock (1 bit).
  - While cfg_lock=1 at ISSUE, writes from any requester other than index 0 are suppressed (no rf_write) and answered with rsp_err=1.
  - Reads and requester 0 are unaffected.
- Undefined: no cfg_lock port; no locking.

Decomposition:
- Package regfile_arb_pkg:
  - FSM state enum.
  - ADDR_W/DATA_W defaults.
  - Transaction struct {we, addr, wdata, idx}.
  - Error-code localparams.
- Sub-module rr_arbiter:
  - Parameterised NUM_REQ.
  - valid vector + pointer -> one-hot grant + index.
  - Combinational, with the pointer register inside.

Test Plan:
- Req0 writes addr 0x05 data 0xA5, then reads 0x05 -> rf_write one cycle with 0x05/0xA5; rsp_valid[0] at cycle 2 with err=0; read rsp at cycle 3 with rsp_rdata=0xA5.
- Req0 and req1 both valid from reset -> grants 0,1,0,1 alternating across 4 back-to-back reads; req_ready never two-hot.
- Req1 writes addr 0x43 (=67) -> no rf_write, rsp_err=1; read of 0xFF returns rsp_rdata=0x00, err=1.
- Hold rsp_ready[0]=0 for 5 cycles during a read -> rsp_valid/rsp_rdata stable; req1 not accepted until 1 cycle after rsp_ready.
- Assert reset_n low during ISSUE of a write -> rf_write=0, all outputs 0; after release, state IDLE and pointer 0.
- With REGFILE_ARB_WRITE_LOCK_EN and cfg_lock=1: req1 write 0x10/0x3C -> no rf_write, rsp_err=1; req0 same write -> rf_write, err=0.
